// File: rtl/alu_rr_arbiter.sv
// Two-requester front end sharing one 8-bit add/sub ALU; round-robin or fixed
// priority grant, one operation in flight, result returned with requester ID.
`timescale 1ns/1ps

module alu_sub_and_n #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] io_in_a,
  input  logic [WIDTH-1:0] io_in_b,
  input  logic             io_in_sel,
  output logic [WIDTH-1:0] io_out
);
  assign io_out = io_in_sel ? (io_in_a - io_in_b) : (io_in_a + io_in_b);
endmodule

module alu_rr_arbiter #(
  parameter int unsigned WIDTH         = 8,
  parameter bit          PRIORITY_MODE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_req0_valid,
  output logic             io_req0_ready,
  input  logic [WIDTH-1:0] io_req0_a,
  input  logic [WIDTH-1:0] io_req0_b,
  input  logic             io_req0_sel,
  input  logic             io_req1_valid,
  output logic             io_req1_ready,
  input  logic [WIDTH-1:0] io_req1_a,
  input  logic [WIDTH-1:0] io_req1_b,
  input  logic             io_req1_sel,
  output logic             io_rsp_valid,
  input  logic             io_rsp_ready,
  output logic             io_rsp_id,
  output logic [WIDTH-1:0] io_rsp_result,
  output logic             io_rsp_overflow,
  output logic             io_rsp_zero,
  output logic             io_busy
);
  localparam int unsigned MSB = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic             op_sel_q, op_sel_d, op_id_q, op_id_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_ovf_q, rsp_ovf_d, rsp_zero_q, rsp_zero_d;
  logic             busy_q, busy_d;

  logic             grant_id;
  logic             accept;
  logic [WIDTH-1:0] alu_r;
  logic             alu_ovf;

  // Grant selection; ready is also held low while reset is asserted
  always_comb begin
    grant_id = 1'b0;
    if (io_req0_valid && io_req1_valid) begin
      grant_id = PRIORITY_MODE ? 1'b0 : ~last_grant_q;
    end else begin
      grant_id = io_req1_valid;
    end
  end

  assign accept        = (state_q == IDLE) & (io_req0_valid | io_req1_valid) & reset;
  assign io_req0_ready = accept & ~grant_id;
  assign io_req1_ready = accept & grant_id;

  alu_sub_and_n #(.WIDTH(WIDTH)) u_alu (
    .io_in_a  (op_a_q),
    .io_in_b  (op_b_q),
    .io_in_sel(op_sel_q),
    .io_out   (alu_r)
  );

  // Signed overflow from operands and result; the ALU's own flags are not used
  assign alu_ovf = op_sel_q ? ((op_a_q[MSB] != op_b_q[MSB]) & (alu_r[MSB] != op_a_q[MSB]))
                            : ((op_a_q[MSB] == op_b_q[MSB]) & (alu_r[MSB] != op_a_q[MSB]));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_sel_d     = op_sel_q;
    op_id_d      = op_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_zero_d   = rsp_zero_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = EXEC;
          last_grant_d = grant_id;
          op_id_d      = grant_id;
          op_a_d       = grant_id ? io_req1_a   : io_req0_a;
          op_b_d       = grant_id ? io_req1_b   : io_req0_b;
          op_sel_d     = grant_id ? io_req1_sel : io_req0_sel;
        end
      end
      EXEC: begin
        state_d      = RESP;
        rsp_valid_d  = 1'b1;
        rsp_id_d     = op_id_q;
        rsp_result_d = alu_r;
        rsp_ovf_d    = alu_ovf;
        rsp_zero_d   = (alu_r == '0);
      end
      RESP: begin
        if (io_rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_sel_q     <= 1'b0;
      op_id_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_zero_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_sel_q     <= op_sel_d;
      op_id_q      <= op_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_zero_q   <= rsp_zero_d;
      busy_q       <= busy_d;
    end
  end

  assign io_rsp_valid    = rsp_valid_q;
  assign io_rsp_id       = rsp_id_q;
  assign io_rsp_result   = rsp_result_q;
  assign io_rsp_overflow = rsp_ovf_q;
  assign io_rsp_zero     = rsp_zero_q;
  assign io_busy         = busy_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: a round-robin and a fixed-priority
// instance driven by the same stimulus.
`timescale 1ns/1ps

module tb_alu_rr_arbiter;
  logic       clock = 1'b0;
  logic       reset;
  logic       req0_valid, req0_sel, req1_valid, req1_sel, rsp_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;

  logic       rr_req0_ready, rr_req1_ready, rr_rsp_valid, rr_rsp_id, rr_rsp_ovf, rr_rsp_zero, rr_busy;
  logic [7:0] rr_rsp_result;
  logic       fx_req0_ready, fx_req1_ready, fx_rsp_valid, fx_rsp_id, fx_rsp_ovf, fx_rsp_zero, fx_busy;
  logic [7:0] fx_rsp_result;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  alu_rr_arbiter #(.WIDTH(8), .PRIORITY_MODE(1'b0)) u_rr (
    .clock(clock), .reset(reset),
    .io_req0_valid(req0_valid), .io_req0_ready(rr_req0_ready), .io_req0_a(req0_a),
    .io_req0_b(req0_b), .io_req0_sel(req0_sel),
    .io_req1_valid(req1_valid), .io_req1_ready(rr_req1_ready), .io_req1_a(req1_a),
    .io_req1_b(req1_b), .io_req1_sel(req1_sel),
    .io_rsp_valid(rr_rsp_valid), .io_rsp_ready(rsp_ready), .io_rsp_id(rr_rsp_id),
    .io_rsp_result(rr_rsp_result), .io_rsp_overflow(rr_rsp_ovf), .io_rsp_zero(rr_rsp_zero),
    .io_busy(rr_busy)
  );

  alu_rr_arbiter #(.WIDTH(8), .PRIORITY_MODE(1'b1)) u_fx (
    .clock(clock), .reset(reset),
    .io_req0_valid(req0_valid), .io_req0_ready(fx_req0_ready), .io_req0_a(req0_a),
    .io_req0_b(req0_b), .io_req0_sel(req0_sel),
    .io_req1_valid(req1_valid), .io_req1_ready(fx_req1_ready), .io_req1_a(req1_a),
    .io_req1_b(req1_b), .io_req1_sel(req1_sel),
    .io_rsp_valid(fx_rsp_valid), .io_rsp_ready(rsp_ready), .io_rsp_id(fx_rsp_id),
    .io_rsp_result(fx_rsp_result), .io_rsp_overflow(fx_rsp_ovf), .io_rsp_zero(fx_rsp_zero),
    .io_busy(fx_busy)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
  endtask

  task automatic set_req(input logic id, input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic sel);
    if (id) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_sel = sel;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_sel = sel;
    end
  endtask

  task automatic drain(input string tag);
    int k = 0;
    rsp_ready = 1'b1;
    while ((rr_busy || fx_busy) && k < 20) begin
      @(negedge clock); #1;
      k++;
    end
    check(tag, 8'({rr_busy, fx_busy}), 8'd0);
  endtask

  // Single op on the round-robin instance, response taken immediately
  task automatic run_op(input string tag, input logic id, input logic [7:0] a, input logic [7:0] b,
                        input logic sel, input logic [7:0] res, input logic ovf, input logic zero);
    @(negedge clock);
    rsp_ready = 1'b1;
    set_req(id, 1'b1, a, b, sel); #1;
    check({tag, "_ready"}, 8'(id ? rr_req1_ready : rr_req0_ready), 8'd1);
    @(negedge clock);
    set_req(id, 1'b0, a, b, sel); #1;
    check({tag, "_exec_busy"}, 8'(rr_busy), 8'd1);
    check({tag, "_exec_nvalid"}, 8'(rr_rsp_valid), 8'd0);
    @(negedge clock); #1;
    check({tag, "_valid"}, 8'(rr_rsp_valid), 8'd1);
    check({tag, "_id"}, 8'(rr_rsp_id), 8'(id));
    check({tag, "_result"}, rr_rsp_result, res);
    check({tag, "_ovf"}, 8'(rr_rsp_ovf), 8'(ovf));
    check({tag, "_zero"}, 8'(rr_rsp_zero), 8'(zero));
    @(negedge clock); #1;
    check({tag, "_done_valid"}, 8'(rr_rsp_valid), 8'd0);
    check({tag, "_done_busy"}, 8'(rr_busy), 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic       eid;
    logic [7:0] eres;
    reset = 1'b0;
    rsp_ready = 1'b0;
    set_req(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
    set_req(1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    #1;
    check("rst_ready0", 8'(rr_req0_ready), 8'd0);
    check("rst_ready1", 8'(rr_req1_ready), 8'd0);
    check("rst_outs", 8'({rr_rsp_valid, rr_rsp_id, rr_rsp_ovf, rr_rsp_zero, rr_busy}), 8'd0);
    check("rst_result", rr_rsp_result, 8'h00);
    set_req(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    set_req(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clock); @(negedge clock);
    reset = 1'b1;

    // T1, T3, wrap, T4 (last_grant ends at 1)
    run_op("t1", 1'b0, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
    run_op("t3_add", 1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b1, 1'b0);
    run_op("t3_sub", 1'b1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b0);
    run_op("wrap", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1);

    @(negedge clock);
    rsp_ready = 1'b0;
    set_req(1'b1, 1'b1, 8'h42, 8'h42, 1'b1); #1;
    check("t4_ready", 8'(rr_req1_ready), 8'd1);
    @(negedge clock);
    set_req(1'b1, 1'b0, 8'h42, 8'h42, 1'b1);
    @(negedge clock); #1;
    check("t4_valid", 8'(rr_rsp_valid), 8'd1);
    check("t4_result", rr_rsp_result, 8'h00);
    check("t4_flags", 8'({rr_rsp_id, rr_rsp_ovf, rr_rsp_zero}), 8'b101);
    set_req(1'b0, 1'b1, 8'h11, 8'h22, 1'b0);
    set_req(1'b1, 1'b1, 8'h33, 8'h44, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock); #1;
      check("t4_hold_valid", 8'(rr_rsp_valid), 8'd1);
      check("t4_hold_result", rr_rsp_result, 8'h00);
      check("t4_hold_flags", 8'({rr_rsp_id, rr_rsp_ovf, rr_rsp_zero}), 8'b101);
      check("t4_hold_readys", 8'({rr_req0_ready, rr_req1_ready, fx_req0_ready, fx_req1_ready}), 8'd0);
    end
    set_req(1'b0, 1'b0, 8'h11, 8'h22, 1'b0);
    set_req(1'b1, 1'b0, 8'h33, 8'h44, 1'b1);
    rsp_ready = 1'b1;
    @(negedge clock); #1;
    check("t4_release_valid", 8'(rr_rsp_valid), 8'd0);
    drain("t4_drain");

    // T2 / T5: both valid continuously, accepts every third cycle
    @(negedge clock);
    rsp_ready = 1'b1;
    set_req(1'b0, 1'b1, 8'h01, 8'h02, 1'b0);
    set_req(1'b1, 1'b1, 8'h0A, 8'h03, 1'b1);
    for (int c = 0; c < 12; c++) begin
      #1;
      eid  = 1'((c / 3) % 2);
      eres = eid ? 8'h07 : 8'h03;
      if (c % 3 == 0) begin
        check("t2_rr_ready0", 8'(rr_req0_ready), 8'(!eid));
        check("t2_rr_ready1", 8'(rr_req1_ready), 8'(eid));
        check("t5_fx_ready", 8'({fx_req0_ready, fx_req1_ready}), 8'b10);
      end else begin
        check("t2_rr_idle_readys", 8'({rr_req0_ready, rr_req1_ready}), 8'd0);
      end
      if (c % 3 == 2) begin
        check("t2_rsp_valid", 8'(rr_rsp_valid), 8'd1);
        check("t2_rsp_id", 8'(rr_rsp_id), 8'(eid));
        check("t2_rsp_result", rr_rsp_result, eres);
        check("t5_fx_rsp_id", 8'(fx_rsp_id), 8'd0);
        check("t5_fx_rsp_result", fx_rsp_result, 8'h03);
      end
      @(negedge clock);
    end
    set_req(1'b0, 1'b0, 8'h01, 8'h02, 1'b0);
    set_req(1'b1, 1'b0, 8'h0A, 8'h03, 1'b1);
    drain("t2_drain");

    @(negedge clock);
    set_req(1'b1, 1'b1, 8'h10, 8'h20, 1'b0); #1;
    check("t5_fx_req1_alone", 8'({fx_req0_ready, fx_req1_ready}), 8'b01);
    @(negedge clock);
    set_req(1'b1, 1'b0, 8'h10, 8'h20, 1'b0);
    @(negedge clock); #1;
    check("t5_fx_rsp", 8'({fx_rsp_valid, fx_rsp_id}), 8'b11);
    check("t5_fx_result", fx_rsp_result, 8'h30);
    drain("t5_drain");

    // T6: reset during EXEC drops the op; tie afterwards grants req0
    @(negedge clock);
    set_req(1'b0, 1'b1, 8'h05, 8'h05, 1'b0); #1;
    check("t6_ready", 8'(rr_req0_ready), 8'd1);
    @(negedge clock);
    set_req(1'b1, 1'b1, 8'h09, 8'h01, 1'b1);
    reset = 1'b0; #1;
    check("t6_rst_outs", 8'({rr_rsp_valid, rr_busy, rr_req0_ready, rr_req1_ready, rr_rsp_id}), 8'd0);
    check("t6_rst_result", rr_rsp_result, 8'h00);
    check("t6_rst_fx", 8'({fx_busy, fx_rsp_valid}), 8'd0);
    @(negedge clock); #1;
    check("t6_no_rsp", 8'(rr_rsp_valid), 8'd0);
    reset = 1'b1; #1;
    check("t6_tie_rr", 8'({rr_req0_ready, rr_req1_ready}), 8'b10);
    @(negedge clock);
    set_req(1'b0, 1'b0, 8'h05, 8'h05, 1'b0);
    set_req(1'b1, 1'b0, 8'h09, 8'h01, 1'b1);
    @(negedge clock); #1;
    check("t6_rsp", 8'({rr_rsp_valid, rr_rsp_id}), 8'b10);
    check("t6_result", rr_rsp_result, 8'h0A);
    drain("t6_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
